// File: rtl/ins_encoder.sv
// ---------------------------------------------------------------------------
// ins_encoder
//   Packs ALU instruction fields into the 16-bit CPU instruction word
//   {3'b000, op[3:0], r1[2:0], r2[2:0], r3[2:0]} and writes the words to
//   instruction memory in order. This is the write-side counterpart of the
//   CU decoder and is used by the program loader.
//
//   Fields are buffered in a DEPTH-entry FIFO. The write address
//   auto-increments after each accepted write and returns to 0 once the
//   program has been written. A one-cycle done pulse marks the end of a
//   program.
//
// Parameters
//   DEPTH   FIFO entries (power of two, >= 2)
//   ADDR_W  instruction memory address width
//
// Ports
//   clk        rising-edge clock
//   rst        synchronous active-high reset
//   in_valid   field set valid
//   in_ready   encoder can accept (registered); transfer = in_valid & in_ready
//   in_op      ALU op: 0 add, 1 sub, 2 and, 3 or, 4 sll, 5 srl (>5 illegal)
//   in_r1      destination register  -> word[8:6]
//   in_r2      source 1              -> word[5:3]
//   in_r3      source 2              -> word[2:0]
//   in_last    final instruction of the program
//   mem_we     write request, held until mem_ready
//   mem_addr   write address
//   mem_wdata  encoded word (FIFO head)
//   mem_ready  memory accepts the write this cycle
//   busy       encoder is not idle
//   done       one-cycle pulse: program fully written
//   err        sticky: an illegal op was rejected
//   err_cnt    (only with ENC_ERR_CNT_EN) saturating count of rejected ops
//
// Configuration macro
//   ENC_ERR_CNT_EN  adds the err_cnt output and its counter.
// ---------------------------------------------------------------------------
module ins_encoder #(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [3:0]        in_op,
    input  logic [2:0]        in_r1,
    input  logic [2:0]        in_r2,
    input  logic [2:0]        in_r3,
    input  logic              in_last,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [15:0]       mem_wdata,
    input  logic              mem_ready,
    output logic              busy,
    output logic              done,
`ifdef ENC_ERR_CNT_EN
    output logic              err,
    output logic [7:0]        err_cnt
`else
    output logic              err
`endif
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_FLUSH = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    state_t              state_q, state_d;
    logic [15:0]         fifo_q [DEPTH];
    logic [15:0]         fifo_d [DEPTH];
    logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]    count_q, count_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic                in_ready_q, in_ready_d;
    logic                err_q, err_d;
`ifdef ENC_ERR_CNT_EN
    logic [7:0]          err_cnt_q, err_cnt_d;
`endif

    logic                xfer;
    logic                legal;
    logic                push;
    logic                pop;
    logic [15:0]         word;

    // Next-state computation for FIFO, address, FSM and status flags.
    always_comb begin
        state_d    = state_q;
        fifo_d     = fifo_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        addr_d     = addr_q;
        err_d      = err_q;
`ifdef ENC_ERR_CNT_EN
        err_cnt_d  = err_cnt_q;
`endif

        xfer  = in_valid & in_ready_q;
        legal = (in_op <= 4'd5);
        push  = xfer & legal;
        pop   = (count_q != {CNT_W{1'b0}}) & mem_ready;
        word  = {3'b000, in_op, in_r1, in_r2, in_r3};

        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1'b1);
            addr_d   = addr_q + ADDR_W'(1'b1);   // wraps silently
        end else begin
            rd_ptr_d = rd_ptr_q;
        end

        if (push) begin
            fifo_d[wr_ptr_q] = word;
            wr_ptr_d         = wr_ptr_q + PTR_W'(1'b1);
        end else begin
            wr_ptr_d = wr_ptr_q;
        end

        case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1'b1);
            2'b01:   count_d = count_q - CNT_W'(1'b1);
            default: count_d = count_q;
        endcase

        // Illegal op: handshake completes but the word is dropped.
        if (xfer & ~legal) begin
            err_d = 1'b1;
`ifdef ENC_ERR_CNT_EN
            if (err_cnt_q != 8'hFF) begin
                err_cnt_d = err_cnt_q + 8'd1;
            end else begin
                err_cnt_d = err_cnt_q;
            end
`endif
        end else begin
            err_d = err_q;
        end

        case (state_q)
            ST_IDLE: begin
                if (xfer) begin
                    state_d = in_last ? ST_FLUSH : ST_RUN;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (xfer & in_last) begin
                    state_d = ST_FLUSH;
                end else begin
                    state_d = ST_RUN;
                end
            end
            ST_FLUSH: begin
                // Empty FIFO means no write is being presented.
                if (count_q == {CNT_W{1'b0}}) begin
                    state_d = ST_DONE;
                end else begin
                    state_d = ST_FLUSH;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
                addr_d  = {ADDR_W{1'b0}};
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Ready is registered from next-cycle occupancy and state, so a pop
        // while full reopens the input one cycle later with no path from
        // mem_ready to in_ready.
        in_ready_d = (count_d != CNT_W'(DEPTH)) &&
                     ((state_d == ST_IDLE) || (state_d == ST_RUN));
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            for (int i = 0; i < DEPTH; i++) begin
                fifo_q[i] <= 16'h0000;
            end
            wr_ptr_q   <= {PTR_W{1'b0}};
            rd_ptr_q   <= {PTR_W{1'b0}};
            count_q    <= {CNT_W{1'b0}};
            addr_q     <= {ADDR_W{1'b0}};
            in_ready_q <= 1'b0;
            err_q      <= 1'b0;
`ifdef ENC_ERR_CNT_EN
            err_cnt_q  <= 8'h00;
`endif
        end else begin
            state_q    <= state_d;
            fifo_q     <= fifo_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            addr_q     <= addr_d;
            in_ready_q <= in_ready_d;
            err_q      <= err_d;
`ifdef ENC_ERR_CNT_EN
            err_cnt_q  <= err_cnt_d;
`endif
        end
    end

    assign in_ready  = in_ready_q;
    assign mem_we    = (count_q != {CNT_W{1'b0}});
    assign mem_wdata = fifo_q[rd_ptr_q];
    assign mem_addr  = addr_q;
    assign busy      = (state_q != ST_IDLE);
    assign done      = (state_q == ST_DONE);
    assign err       = err_q;
`ifdef ENC_ERR_CNT_EN
    assign err_cnt   = err_cnt_q;
`endif

endmodule
